// File: rtl/ahb_pkg.sv
// Shared AHB constants, data-phase select encoding and default-slave state type
// for the response multiplexer.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    DSEL_NONE = 3'd0,
    DSEL_S1   = 3'd1,
    DSEL_S2   = 3'd2,
    DSEL_S3   = 3'd3,
    DSEL_S4   = 3'd4,
    DSEL_DEF  = 3'd5
  } dsel_t;

  typedef enum logic [1:0] {
    ST_PASS = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } ds_state_t;

  // hsel[0] is slave 1 and has the highest priority
  function automatic dsel_t decode_dsel(input logic [3:0] hsel, input logic [1:0] htrans);
    if (hsel[0])      return DSEL_S1;
    else if (hsel[1]) return DSEL_S2;
    else if (hsel[2]) return DSEL_S3;
    else if (hsel[3]) return DSEL_S4;
    else if (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ) return DSEL_DEF;
    else              return DSEL_NONE;
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle ERROR FSM (ERR1/ERR2) that overrides the muxed response.
// With AHB_RESP_MUX_TIMEOUT_EN a wait-state watchdog also forces the ERROR sequence.
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic hclk,
  input  logic hreset,
  input  logic hready,
  input  logic next_def,
  input  logic slave_wait,
  output logic ovr_active,
  output logic ovr_hready,
  output logic ovr_hresp,
  output logic force_none
);

  ds_state_t state, next_state;
  logic      timeout_hit;
  logic      abort_q;

`ifdef AHB_RESP_MUX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)
      wait_cnt <= '0;
    else if (hready)
      wait_cnt <= '0;
    else if (slave_wait && wait_cnt != CW'(TIMEOUT_CYCLES))
      wait_cnt <= wait_cnt + 1'b1;
  end

  // Fire on the wait cycle that brings the count to the limit
  assign timeout_hit = (state == ST_PASS) && slave_wait && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)
      abort_q <= 1'b0;
    else if (timeout_hit)
      abort_q <= 1'b1;
    else if (state == ST_ERR2)
      abort_q <= 1'b0;
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  logic unused_wait;
  assign unused_wait = slave_wait;
  assign timeout_hit = 1'b0;
  assign abort_q     = 1'b0;
`endif

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)
      state <= ST_PASS;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_PASS: if (timeout_hit || (hready && next_def)) next_state = ST_ERR1;
      ST_ERR1: next_state = ST_ERR2;
      // An address phase accepted in ERR2 may start the next ERROR at once
      ST_ERR2: next_state = (!abort_q && next_def) ? ST_ERR1 : ST_PASS;
      default: next_state = ST_PASS;
    endcase
  end

  always_comb begin
    ovr_active = (state != ST_PASS);
    ovr_hready = (state != ST_ERR1);
    ovr_hresp  = (state != ST_PASS) ? HRESP_ERROR : HRESP_OKAY;
    force_none = (state == ST_ERR2) && abort_q;
  end

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB response multiplexer: registers the decoder selects and routes the selected
// slave's response back to the master. Optional watchdog: AHB_RESP_MUX_TIMEOUT_EN.
module ahb_resp_mux
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [1:0]            htrans,
  input  logic                  hsel_1,
  input  logic                  hsel_2,
  input  logic                  hsel_3,
  input  logic                  hsel_4,
  input  logic [DATA_WIDTH-1:0] hrdata_1,
  input  logic [DATA_WIDTH-1:0] hrdata_2,
  input  logic [DATA_WIDTH-1:0] hrdata_3,
  input  logic [DATA_WIDTH-1:0] hrdata_4,
  input  logic                  hreadyout_1,
  input  logic                  hreadyout_2,
  input  logic                  hreadyout_3,
  input  logic                  hreadyout_4,
  input  logic                  hresp_1,
  input  logic                  hresp_2,
  input  logic                  hresp_3,
  input  logic                  hresp_4,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hready,
  output logic                  hresp
);

  dsel_t dsel, addr_dsel;
  logic  ovr_active, ovr_hready, ovr_hresp, force_none;
  logic  slave_wait;

  assign addr_dsel = decode_dsel({hsel_4, hsel_3, hsel_2, hsel_1}, htrans);

  // The data-phase select only advances when the current transfer completes
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)
      dsel <= DSEL_NONE;
    else if (hready)
      dsel <= force_none ? DSEL_NONE : addr_dsel;
  end

  always_comb begin
    hrdata = '0;
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    case (dsel)
      DSEL_S1: begin hrdata = hrdata_1; hready = hreadyout_1; hresp = hresp_1; end
      DSEL_S2: begin hrdata = hrdata_2; hready = hreadyout_2; hresp = hresp_2; end
      DSEL_S3: begin hrdata = hrdata_3; hready = hreadyout_3; hresp = hresp_3; end
      DSEL_S4: begin hrdata = hrdata_4; hready = hreadyout_4; hresp = hresp_4; end
      default: ;
    endcase
    if (ovr_active) begin
      hrdata = '0;
      hready = ovr_hready;
      hresp  = ovr_hresp;
    end
  end

  // Outside an ERROR sequence, hready low can only mean a slave wait state
  assign slave_wait = !ovr_active && !hready;

  ahb_default_slave #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_default_slave (
    .hclk       (hclk),
    .hreset     (hreset),
    .hready     (hready),
    .next_def   (addr_dsel == DSEL_DEF),
    .slave_wait (slave_wait),
    .ovr_active (ovr_active),
    .ovr_hready (ovr_hready),
    .ovr_hresp  (ovr_hresp),
    .force_none (force_none)
  );

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Scoreboard bench for ahb_resp_mux: stimulus pushes hand-computed expected
// responses, a monitor pops and compares them each cycle.
module tb_ahb_resp_mux;
  import ahb_pkg::*;

  localparam int DW = 32;

  logic          hclk = 1'b0;
  logic          hreset;
  logic [1:0]    htrans;
  logic          hsel_1, hsel_2, hsel_3, hsel_4;
  logic [DW-1:0] hrdata_1, hrdata_2, hrdata_3, hrdata_4;
  logic          hreadyout_1, hreadyout_2, hreadyout_3, hreadyout_4;
  logic          hresp_1, hresp_2, hresp_3, hresp_4;
  logic [DW-1:0] hrdata;
  logic          hready;
  logic          hresp;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_data_q[$];
  logic          exp_rdy_q[$];
  logic          exp_rsp_q[$];
  string         exp_name_q[$];

  always #5 hclk = ~hclk;

  ahb_resp_mux #(
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .hclk(hclk), .hreset(hreset), .htrans(htrans),
    .hsel_1(hsel_1), .hsel_2(hsel_2), .hsel_3(hsel_3), .hsel_4(hsel_4),
    .hrdata_1(hrdata_1), .hrdata_2(hrdata_2), .hrdata_3(hrdata_3), .hrdata_4(hrdata_4),
    .hreadyout_1(hreadyout_1), .hreadyout_2(hreadyout_2),
    .hreadyout_3(hreadyout_3), .hreadyout_4(hreadyout_4),
    .hresp_1(hresp_1), .hresp_2(hresp_2), .hresp_3(hresp_3), .hresp_4(hresp_4),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  task automatic push_exp(input logic [DW-1:0] ed, input logic er, input logic es, input string nm);
    exp_data_q.push_back(ed);
    exp_rdy_q.push_back(er);
    exp_rsp_q.push_back(es);
    exp_name_q.push_back(nm);
  endtask

  // One bus cycle: drive address-phase and slave signals, queue the expected master response
  task automatic apply_stimulus(input logic [1:0] tr, input logic [3:0] sel, input logic [3:0] rdy,
                                input logic [3:0] rsp, input logic [DW-1:0] ed, input logic er,
                                input logic es, input string nm);
    @(posedge hclk);
    #1;
    htrans = tr;
    {hsel_4, hsel_3, hsel_2, hsel_1} = sel;
    {hreadyout_4, hreadyout_3, hreadyout_2, hreadyout_1} = rdy;
    {hresp_4, hresp_3, hresp_2, hresp_1} = rsp;
    push_exp(ed, er, es, nm);
  endtask

  task automatic check_output();
    logic [DW-1:0] ed;
    logic          er, es;
    string         nm;
    ed = exp_data_q.pop_front();
    er = exp_rdy_q.pop_front();
    es = exp_rsp_q.pop_front();
    nm = exp_name_q.pop_front();
    checks++;
    if (hrdata !== ed || hready !== er || hresp !== es) begin
      errors++;
      $display("[TB] FAIL %s: got hrdata=%h hready=%b hresp=%b, expected hrdata=%h hready=%b hresp=%b",
               nm, hrdata, hready, hresp, ed, er, es);
    end
  endtask

  // Monitor also wakes on reset assertion so the asynchronous clear is observed mid-cycle
  initial begin
    forever begin
      @(negedge hclk or posedge hreset);
      #1;
      if (exp_data_q.size() > 0) check_output();
    end
  end

  initial begin
    hreset = 1'b1;
    htrans = HTRANS_IDLE;
    {hsel_4, hsel_3, hsel_2, hsel_1} = 4'b0000;
    hrdata_1 = 32'hA5A5_0001;
    hrdata_2 = 32'hA5A5_0002;
    hrdata_3 = 32'hA5A5_0003;
    hrdata_4 = 32'hA5A5_0004;
    {hreadyout_4, hreadyout_3, hreadyout_2, hreadyout_1} = 4'b1111;
    {hresp_4, hresp_3, hresp_2, hresp_1} = 4'b0000;
    repeat (2) @(posedge hclk);
    #1 hreset = 1'b0;

    apply_stimulus(HTRANS_IDLE,   4'b0000, 4'b1111, 4'b0000, 32'h0, 1'b1, 1'b0, "reset_idle");

    apply_stimulus(HTRANS_NONSEQ, 4'b0010, 4'b1111, 4'b0000, 32'h0, 1'b1, 1'b0, "s2_addr");
    apply_stimulus(HTRANS_IDLE,   4'b0000, 4'b1111, 4'b0000, 32'hA5A5_0002, 1'b1, 1'b0, "s2_data");

    apply_stimulus(HTRANS_NONSEQ, 4'b1001, 4'b1111, 4'b0000, 32'h0, 1'b1, 1'b0, "prio_addr");
    apply_stimulus(HTRANS_IDLE,   4'b0000, 4'b1111, 4'b0001, 32'hA5A5_0001, 1'b1, 1'b1, "prio_data_s1");

    apply_stimulus(HTRANS_NONSEQ, 4'b1000, 4'b1111, 4'b0000, 32'h0, 1'b1, 1'b0, "s4_addr");
    apply_stimulus(HTRANS_IDLE,   4'b0000, 4'b1111, 4'b1000, 32'hA5A5_0004, 1'b1, 1'b1, "s4_err_data");

    apply_stimulus(HTRANS_NONSEQ, 4'b0100, 4'b1111, 4'b0000, 32'h0, 1'b1, 1'b0, "s3_addr");
    apply_stimulus(HTRANS_NONSEQ, 4'b0001, 4'b1011, 4'b0000, 32'hA5A5_0003, 1'b0, 1'b0, "s3_wait1");
    apply_stimulus(HTRANS_NONSEQ, 4'b0000, 4'b1011, 4'b0000, 32'hA5A5_0003, 1'b0, 1'b0, "s3_wait2");
    apply_stimulus(HTRANS_NONSEQ, 4'b0001, 4'b1011, 4'b0000, 32'hA5A5_0003, 1'b0, 1'b0, "s3_wait3");
    apply_stimulus(HTRANS_IDLE,   4'b0000, 4'b1111, 4'b0000, 32'hA5A5_0003, 1'b1, 1'b0, "s3_done");
    apply_stimulus(HTRANS_IDLE,   4'b0000, 4'b1111, 4'b0000, 32'h0, 1'b1, 1'b0, "s3_after_none");

    apply_stimulus(HTRANS_NONSEQ, 4'b0000, 4'b1111, 4'b0000, 32'h0, 1'b1, 1'b0, "def_addr");
    apply_stimulus(HTRANS_IDLE,   4'b0000, 4'b1111, 4'b0000, 32'h0, 1'b0, 1'b1, "def_err1");
    apply_stimulus(HTRANS_IDLE,   4'b0000, 4'b1111, 4'b0000, 32'h0, 1'b1, 1'b1, "def_err2");
    apply_stimulus(HTRANS_IDLE,   4'b0000, 4'b1111, 4'b0000, 32'h0, 1'b1, 1'b0, "def_idle");

    apply_stimulus(HTRANS_NONSEQ, 4'b0000, 4'b1111, 4'b0000, 32'h0, 1'b1, 1'b0, "b2b_addr");
    apply_stimulus(HTRANS_NONSEQ, 4'b0000, 4'b1111, 4'b0000, 32'h0, 1'b0, 1'b1, "b2b_err1a");
    apply_stimulus(HTRANS_NONSEQ, 4'b0000, 4'b1111, 4'b0000, 32'h0, 1'b1, 1'b1, "b2b_err2a");
    apply_stimulus(HTRANS_IDLE,   4'b0000, 4'b1111, 4'b0000, 32'h0, 1'b0, 1'b1, "b2b_err1b");
    apply_stimulus(HTRANS_IDLE,   4'b0000, 4'b1111, 4'b0000, 32'h0, 1'b1, 1'b1, "b2b_err2b");
    apply_stimulus(HTRANS_BUSY,   4'b0000, 4'b1111, 4'b0000, 32'h0, 1'b1, 1'b0, "busy_none");
    apply_stimulus(HTRANS_IDLE,   4'b0000, 4'b1111, 4'b0000, 32'h0, 1'b1, 1'b0, "idle_none");

    apply_stimulus(HTRANS_NONSEQ, 4'b0000, 4'b1111, 4'b0000, 32'h0, 1'b1, 1'b0, "def2_addr");
    apply_stimulus(HTRANS_IDLE,   4'b0000, 4'b1111, 4'b0000, 32'h0, 1'b0, 1'b1, "def2_err1");
    apply_stimulus(HTRANS_NONSEQ, 4'b0010, 4'b1111, 4'b0000, 32'h0, 1'b1, 1'b1, "def2_err2_s2addr");
    apply_stimulus(HTRANS_IDLE,   4'b0000, 4'b1111, 4'b0000, 32'hA5A5_0002, 1'b1, 1'b0, "after_err2_s2data");

    apply_stimulus(HTRANS_NONSEQ, 4'b0000, 4'b1111, 4'b0000, 32'h0, 1'b1, 1'b0, "rst_addr");
    apply_stimulus(HTRANS_IDLE,   4'b0000, 4'b1111, 4'b0000, 32'h0, 1'b0, 1'b1, "rst_err1");
    @(negedge hclk);
    #2;
    push_exp(32'h0, 1'b1, 1'b0, "rst_async");
    hreset = 1'b1;
    @(posedge hclk);
    #1 hreset = 1'b0;
    apply_stimulus(HTRANS_IDLE,   4'b0000, 4'b1111, 4'b0000, 32'h0, 1'b1, 1'b0, "post_reset");

`ifdef AHB_RESP_MUX_TIMEOUT_EN
    apply_stimulus(HTRANS_NONSEQ, 4'b0010, 4'b1111, 4'b0000, 32'h0, 1'b1, 1'b0, "to_addr");
    for (int i = 0; i < 4; i++)
      apply_stimulus(HTRANS_IDLE, 4'b0000, 4'b1101, 4'b0000, 32'hA5A5_0002, 1'b0, 1'b0, "to_wait");
    apply_stimulus(HTRANS_IDLE,   4'b0000, 4'b1101, 4'b0000, 32'h0, 1'b0, 1'b1, "to_err1");
    apply_stimulus(HTRANS_IDLE,   4'b0000, 4'b1101, 4'b0000, 32'h0, 1'b1, 1'b1, "to_err2");
    apply_stimulus(HTRANS_IDLE,   4'b0000, 4'b1101, 4'b0000, 32'h0, 1'b1, 1'b0, "to_none");
`endif

    // Let the monitor drain, with a bounded wait
    for (int c = 0; c < 20 && exp_data_q.size() > 0; c++) @(posedge hclk);
    if (exp_data_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_data_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
